fetch_decode_queue: RTL and testbench

Instruction buffer between the fetch stage and the decode stage. It captures each fetched instruction with its PC and incremented PC into a small circular FIFO, then presents them to decode under a valid/ready handshake. This decouples decode stalls from the fetch PC loop. On a taken branch it flushes all wrong-path instructions in one cycle.

---
 rtl/fetch_decode_queue.sv | 129 ++++++++++++
 tb/tb_fetch_decode_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular instruction buffer between fetch and decode.
// Holds {instruction, pc, pc_plus4} entries in FIFO order. A taken branch
// flushes every wrong-path entry in one cycle.
//
// Handshake: a transfer happens on a rising edge only when valid and ready
// are both high in that cycle. The producer holds its payload stable while
// valid=1 and ready=0. in_ready depends only on occupancy, never on
// out_ready, so there is no combinational path from decode back to fetch.

`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif
`ifndef WORD
`define WORD 64
`endif

module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [`INSTR_LEN-1:0] in_instruction,
  input  logic [`WORD-1:0]      in_pc,
  input  logic [`WORD-1:0]      in_pc_plus4,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [`INSTR_LEN-1:0] out_instruction,
  output logic [`WORD-1:0]      out_pc,
  output logic [`WORD-1:0]      out_pc_plus4,
  output logic [CNT_W-1:0]      count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [`INSTR_LEN-1:0] instr_q [DEPTH];
  logic [`INSTR_LEN-1:0] instr_d [DEPTH];
  logic [`WORD-1:0]      pc_q    [DEPTH];
  logic [`WORD-1:0]      pc_d    [DEPTH];
  logic [`WORD-1:0]      pc4_q   [DEPTH];
  logic [`WORD-1:0]      pc4_d   [DEPTH];

  logic push;
  logic pop;

  // Handshake qualifiers derived purely from occupancy.
  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Pointer and occupancy next-state; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage next-state: write the incoming entry at the tail unless flushed.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (push && !flush) begin
      instr_d[wr_ptr_q] = in_instruction;
      pc_d[wr_ptr_q]    = in_pc;
      pc4_d[wr_ptr_q]   = in_pc_plus4;
    end
  end

  // Control state with asynchronous clear; dropping entries is immediate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; outputs are gated while empty.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
    pc4_q   <= pc4_d;
  end

  // Head entry presented to decode, forced to zero when nothing is queued.
  always_comb begin
    out_instruction = '0;
    out_pc          = '0;
    out_pc_plus4    = '0;
    if (out_valid) begin
      out_instruction = instr_q[rd_ptr_q];
      out_pc          = pc_q[rd_ptr_q];
      out_pc_plus4    = pc4_q[rd_ptr_q];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Testbench for fetch_decode_queue: directed scenarios plus a random run,
// all checked against a queue-based reference model of the FIFO.

`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif
`ifndef WORD
`define WORD 64
`endif

module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int EW    = `INSTR_LEN + 2 * `WORD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [`INSTR_LEN-1:0] in_instruction = '0;
  logic [`WORD-1:0]      in_pc = '0;
  logic [`WORD-1:0]      in_pc_plus4 = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [`INSTR_LEN-1:0] out_instruction;
  logic [`WORD-1:0]      out_pc;
  logic [`WORD-1:0]      out_pc_plus4;
  logic [CNT_W-1:0]      count;

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc), .in_pc_plus4(in_pc_plus4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .count(count)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // Advance one clock edge and update the model from the inputs seen there.
  task automatic tick();
    bit do_push, do_pop;
    @(posedge clk);
    do_push = in_valid && (exp_q.size() < DEPTH);
    do_pop  = out_ready && (exp_q.size() > 0);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({in_instruction, in_pc, in_pc_plus4});
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_push(input logic v, input logic [`WORD-1:0] pc);
    in_valid       = v;
    in_pc          = pc;
    in_pc_plus4    = pc + 64'd4;
    in_instruction = 32'h1300_0013 ^ pc[31:0];
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++;
    if ({out_instruction, out_pc, out_pc_plus4} !== '0) begin
      bad++; $display("FAIL reset_out_zero got=%h exp=0", {out_instruction, out_pc, out_pc_plus4});
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_instruction = 32'h8B020020; in_pc = 64'h0; in_pc_plus4 = 64'h4;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    total++;
    if (out_instruction !== 32'h8B020020 || out_pc !== 64'h0 || out_pc_plus4 !== 64'h4) begin
      bad++; $display("FAIL single_data got=%h/%h/%h exp=8b020020/0/4", out_instruction, out_pc, out_pc_plus4);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      bad++; $display("FAIL single_pop got valid=%b count=%0d exp valid=0 count=0", out_valid, count);
    end
  endtask

  task automatic test_fill_full();
    logic [`WORD-1:0] exp_pc;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive_push(1'b1, 64'(4 * i)); tick(); end
    total++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      bad++; $display("FAIL full_state got count=%0d in_ready=%b exp count=4 in_ready=0", count, in_ready);
    end
    drive_push(1'b1, 64'h10);
    tick();
    in_valid = 1'b0;
    total++;
    if (count !== 3'd4) begin bad++; $display("FAIL full_ignore got=%0d exp=4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 64'(4 * i);
      total++;
      if (out_pc !== exp_pc || out_valid !== 1'b1) begin
        bad++; $display("FAIL drain_order[%0d] got pc=%h valid=%b exp pc=%h valid=1", i, out_pc, out_valid, exp_pc);
      end
      tick();
    end
    out_ready = 1'b0;
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL drain_empty got count=%0d valid=%b exp 0/0", count, out_valid);
    end
  endtask

  task automatic test_stream();
    logic [`WORD-1:0] exp_pc;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_push(1'b1, 64'(4 * i));
      if (i > 0) begin
        exp_pc = 64'(4 * (i - 1));
        total++;
        if (count !== 3'd1 || out_pc !== exp_pc) begin
          bad++; $display("FAIL stream[%0d] got count=%0d pc=%h exp count=1 pc=%h", i, count, out_pc, exp_pc);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (out_pc !== 64'h24) begin bad++; $display("FAIL stream_last got=%h exp=24", out_pc); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive_push(1'b1, 64'h200 + 64'(4 * i)); tick(); end
    flush = 1'b1; drive_push(1'b1, 64'h40); out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_clear got count=%0d valid=%b exp 0/0", count, out_valid);
    end
    drive_push(1'b1, 64'h80);
    tick();
    in_valid = 1'b0;
    total++;
    if (out_pc !== 64'h80 || count !== 3'd1) begin
      bad++; $display("FAIL flush_next got pc=%h count=%0d exp pc=80 count=1", out_pc, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_full_simul();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin drive_push(1'b1, 64'h300 + 64'(4 * i)); tick(); end
    drive_push(1'b1, 64'h100); out_ready = 1'b1;
    tick();
    total++;
    if (count !== 3'd3) begin bad++; $display("FAIL full_simul_pop got=%0d exp=3", count); end
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    total++;
    if (count !== 3'd4) begin bad++; $display("FAIL full_simul_push got=%0d exp=4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (exp_q.size() == 0 || {out_instruction, out_pc, out_pc_plus4} !== exp_q[0]) begin
        bad++; $display("FAIL full_simul_drain[%0d] got pc=%h", i, out_pc);
      end
      tick();
    end
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL full_simul_empty got=%0d exp=0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive_push(1'b1, 64'h500 + 64'(4 * i)); tick(); end
    in_valid = 1'b0;
    total++;
    if (count !== 3'd3) begin bad++; $display("FAIL areset_pre got=%0d exp=3", count); end
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL areset_now got count=%0d valid=%b ready=%b exp 0/0/1", count, out_valid, in_ready);
    end
    #1 rst_n = 1'b1;
    tick();
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL areset_post got=%0d exp=0", count); end
  endtask

  task automatic test_random();
    logic [EW-1:0] exp_head;
    for (int n = 0; n < 400; n++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 29) == 0);
      in_instruction = $urandom;
      in_pc          = {$urandom, $urandom};
      in_pc_plus4    = in_pc + 64'd4;
      exp_head       = (exp_q.size() > 0) ? exp_q[0] : '0;
      total++;
      if (count !== CNT_W'(exp_q.size()) || out_valid !== (exp_q.size() > 0) ||
          in_ready !== (exp_q.size() < DEPTH) ||
          {out_instruction, out_pc, out_pc_plus4} !== exp_head) begin
        bad++;
        $display("FAIL random[%0d] got count=%0d valid=%b ready=%b pc=%h exp count=%0d pc=%h",
                 n, count, out_valid, in_ready, out_pc, exp_q.size(), exp_head[2*`WORD-1:`WORD]);
      end
      tick();
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single();
    test_fill_full();
    test_stream();
    test_flush();
    test_full_simul();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
